// File: rtl/rtr_route_gen_pkg.sv
// Shared types and helpers for the per-VC route generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rtr_route_gen_pkg;

    localparam int line_neighbors_per_dim = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } rg_state_t;

    function automatic int clogb(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rtr_dor_next_hop.sv
// Dimension-order next hop: first differing dimension (lowest first) picks the port.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module rtr_dor_next_hop #(
    parameter int num_dimensions       = 2,
    parameter int dim_addr_width       = 2,
    parameter int num_nodes_per_router = 1,
    parameter int node_addr_width      = 1,
    parameter int num_ports            = 5
) (
    input  logic [num_dimensions*dim_addr_width-1:0] router_address,
    input  logic [num_dimensions*dim_addr_width-1:0] target_addr,
    input  logic [node_addr_width-1:0]               dest_node,
    output logic [num_ports-1:0]                     op
);

    logic found;

    always_comb begin
        op    = '0;
        found = 1'b0;
        for (int d = 0; d < num_dimensions; d++) begin
            if (!found && (target_addr[d*dim_addr_width +: dim_addr_width] !=
                           router_address[d*dim_addr_width +: dim_addr_width])) begin
                found = 1'b1;
                // Minus-direction port is even, plus-direction port is odd.
                if (target_addr[d*dim_addr_width +: dim_addr_width] <
                    router_address[d*dim_addr_width +: dim_addr_width])
                    op = num_ports'(1) << (2*d);
                else
                    op = num_ports'(1) << (2*d + 1);
            end
        end
        if (!found) begin
            for (int n = 0; n < num_nodes_per_router; n++) begin
                if (dest_node == node_addr_width'(n))
                    op = num_ports'(1) << (num_dimensions*2 + n);
            end
        end
    end

endmodule

// File: rtl/rtr_route_gen.sv
// Per-input-VC phased DOR route unit: captures head, holds route until tail.
// Latency: route and route_valid register one cycle after each flit of the packet.
// Backpressure: none; heads arriving mid-packet are dropped and flagged.
module rtr_route_gen
    import rtr_route_gen_pkg::*;
#(
    parameter int num_message_classes   = 2,
    parameter int num_resource_classes  = 2,
    parameter int num_vcs_per_class     = 1,
    parameter int num_dimensions        = 2,
    parameter int num_routers_per_dim   = 4,
    parameter int num_nodes_per_router  = 1,
    parameter int num_neighbors_per_dim = line_neighbors_per_dim,
    parameter int num_ports             = num_dimensions*num_neighbors_per_dim + num_nodes_per_router,
    parameter int port_id               = 0,
    parameter int vc_id                 = 0,
    parameter int dim_addr_width        = clogb(num_routers_per_dim),
    parameter int node_addr_width       = (clogb(num_nodes_per_router) > 1) ? clogb(num_nodes_per_router) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [num_dimensions*dim_addr_width-1:0] router_address,
    input  logic                                     flit_valid,
    input  logic                                     flit_head,
    input  logic                                     flit_tail,
    input  logic [num_dimensions*dim_addr_width-1:0] dest_addr,
    input  logic [node_addr_width-1:0]               dest_node,
    input  logic [num_dimensions*dim_addr_width-1:0] int_addr,
    output logic                                     route_valid,
    output logic [num_ports-1:0]                     route_op,
    output logic [num_resource_classes-1:0]          route_orc,
    output logic [1:0]                               errors
);

    localparam int  num_vcs       = num_message_classes*num_resource_classes*num_vcs_per_class;
    localparam int  resource_class = ((vc_id % num_vcs) / num_vcs_per_class) % num_resource_classes;
    localparam bit  has_next_class = resource_class < num_resource_classes - 1;
    localparam bit  eject_input    = port_id >= num_dimensions*2;
    localparam int  rc_up          = has_next_class ? resource_class + 1 : resource_class;

    rg_state_t                     state, state_nxt;
    logic                          rv_nxt;
    logic                          load;
    logic                          proto_err;
    logic                          route_err;
    logic                          at_int;
    logic                          use_int;
    logic                          dest_ok;
    logic [num_ports-1:0]          op_int, op_dst, op_nxt;
    logic [num_resource_classes-1:0] orc_nxt;

    rtr_dor_next_hop #(
        .num_dimensions      (num_dimensions),
        .dim_addr_width      (dim_addr_width),
        .num_nodes_per_router(num_nodes_per_router),
        .node_addr_width     (node_addr_width),
        .num_ports           (num_ports)
    ) u_hop_int (
        .router_address(router_address),
        .target_addr   (int_addr),
        .dest_node     (dest_node),
        .op            (op_int)
    );

    rtr_dor_next_hop #(
        .num_dimensions      (num_dimensions),
        .dim_addr_width      (dim_addr_width),
        .num_nodes_per_router(num_nodes_per_router),
        .node_addr_width     (node_addr_width),
        .num_ports           (num_ports)
    ) u_hop_dst (
        .router_address(router_address),
        .target_addr   (dest_addr),
        .dest_node     (dest_node),
        .op            (op_dst)
    );

    // Phase 0 heads for the intermediate router until it is reached; then the class bumps.
    assign at_int  = (router_address == int_addr);
    assign use_int = has_next_class && !at_int;
    assign op_nxt  = use_int ? op_int : op_dst;
    assign orc_nxt = (has_next_class && at_int) ? num_resource_classes'(1) << rc_up
                                                : num_resource_classes'(1) << resource_class;
    assign dest_ok = 32'(dest_node) < num_nodes_per_router;

    always_comb begin
        state_nxt = state;
        rv_nxt    = (state == ST_BUSY);
        load      = 1'b0;
        proto_err = 1'b0;
        if (flit_valid) begin
            case (state)
                ST_IDLE: begin
                    if (flit_head && dest_ok) begin
                        load   = 1'b1;
                        rv_nxt = 1'b1;
                        if (!flit_tail) state_nxt = ST_BUSY;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (flit_head) proto_err = 1'b1;
                    else if (flit_tail) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign route_err = load && ((op_nxt & (num_ports'(1) << port_id)) != '0) &&
                       (!has_next_class || eject_input);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            route_valid <= 1'b0;
            route_op    <= '0;
            route_orc   <= '0;
            errors      <= '0;
        end else begin
            state       <= state_nxt;
            route_valid <= rv_nxt;
            if (load) begin
                route_op  <= op_nxt;
                route_orc <= orc_nxt;
            end
            errors <= errors | {route_err, proto_err};
        end
    end

endmodule

// File: tb/tb_rtr_route_gen.sv
// Directed bench: class-0 and class-1 instances share stimulus; table vectors plus packet sequences.
module tb_rtr_route_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] router_address, dest_addr, int_addr;
    logic       flit_valid, flit_head, flit_tail;
    logic [0:0] dest_node;
    logic       rv0, rv1;
    logic [4:0] op0, op1;
    logic [1:0] orc0, orc1, err0, err1;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    rtr_route_gen #(.vc_id(0)) dut0 (
        .clk(clk), .reset(reset), .router_address(router_address),
        .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
        .dest_addr(dest_addr), .dest_node(dest_node), .int_addr(int_addr),
        .route_valid(rv0), .route_op(op0), .route_orc(orc0), .errors(err0)
    );

    rtr_route_gen #(.vc_id(1)) dut1 (
        .clk(clk), .reset(reset), .router_address(router_address),
        .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
        .dest_addr(dest_addr), .dest_node(dest_node), .int_addr(int_addr),
        .route_valid(rv1), .route_op(op1), .route_orc(orc1), .errors(err1)
    );

    typedef struct {
        logic [3:0] rtr, intm, dst;
        logic [4:0] op0;
        logic [1:0] orc0;
        logic [4:0] op1;
        logic [1:0] orc1;
        logic [1:0] err1;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [3:0] xy(input int x, input int y);
        return 4'((y << 2) | x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flit(input logic v, input logic h, input logic t);
        flit_valid = v;
        flit_head  = h;
        flit_tail  = t;
        tick();
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_hdr(input logic [3:0] rtr, input logic [3:0] im, input logic [3:0] dst);
        router_address = rtr;
        int_addr       = im;
        dest_addr      = dst;
        dest_node      = 1'b0;
    endtask

    initial begin
        // rtr, int, dst | class0 op/orc | class1 op/orc/errors (class1 input port 0 is a turn-back)
        vecs[0] = '{xy(1,1), xy(3,1), xy(0,2), 5'b00010, 2'b01, 5'b00001, 2'b10, 2'b10};
        vecs[1] = '{xy(3,1), xy(3,1), xy(3,0), 5'b00100, 2'b10, 5'b00100, 2'b10, 2'b00};
        vecs[2] = '{xy(1,1), xy(2,3), xy(1,1), 5'b00010, 2'b01, 5'b10000, 2'b10, 2'b00};
        vecs[3] = '{xy(2,2), xy(2,2), xy(2,2), 5'b10000, 2'b10, 5'b10000, 2'b10, 2'b00};
        vecs[4] = '{xy(0,3), xy(0,0), xy(3,3), 5'b00100, 2'b01, 5'b00010, 2'b10, 2'b00};
        vecs[5] = '{xy(3,0), xy(0,0), xy(3,2), 5'b00001, 2'b01, 5'b01000, 2'b10, 2'b00};
        vecs[6] = '{xy(1,0), xy(3,0), xy(1,3), 5'b00010, 2'b01, 5'b01000, 2'b10, 2'b00};

        reset = 1'b0;
        flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0;
        set_hdr(xy(0,0), xy(0,0), xy(0,0));
        tick();
        do_reset();
        check("rst_rv",   32'(rv0),  32'd0);
        check("rst_op",   32'(op0),  32'd0);
        check("rst_orc",  32'(orc0), 32'd0);
        check("rst_err",  32'(err0), 32'd0);

        // Single-flit packets: one-cycle route_valid pulse.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_hdr(vecs[i].rtr, vecs[i].intm, vecs[i].dst);
            flit(1'b1, 1'b1, 1'b1);
            check($sformatf("v%0d_rv0", i),   32'(rv0),  32'd1);
            check($sformatf("v%0d_op0", i),   32'(op0),  32'(vecs[i].op0));
            check($sformatf("v%0d_orc0", i),  32'(orc0), 32'(vecs[i].orc0));
            check($sformatf("v%0d_err0", i),  32'(err0), 32'd0);
            check($sformatf("v%0d_op1", i),   32'(op1),  32'(vecs[i].op1));
            check($sformatf("v%0d_orc1", i),  32'(orc1), 32'(vecs[i].orc1));
            check($sformatf("v%0d_err1", i),  32'(err1), 32'(vecs[i].err1));
            tick();
            check($sformatf("v%0d_rv0_off", i), 32'(rv0), 32'd0);
            check($sformatf("v%0d_rv1_off", i), 32'(rv1), 32'd0);
        end

        // Three-flit packet; header inputs change after the head and must be ignored.
        do_reset();
        set_hdr(xy(3,1), xy(3,1), xy(3,0));
        flit(1'b1, 1'b1, 1'b0);
        check("pkt_head_rv",  32'(rv0),  32'd1);
        check("pkt_head_op",  32'(op0),  32'b00100);
        check("pkt_head_orc", 32'(orc0), 32'b10);
        set_hdr(xy(3,1), xy(0,0), xy(0,0));
        flit(1'b1, 1'b0, 1'b0);
        check("pkt_body_rv",  32'(rv0),  32'd1);
        check("pkt_body_op",  32'(op0),  32'b00100);
        flit(1'b1, 1'b0, 1'b1);
        check("pkt_tail_rv",  32'(rv0),  32'd1);
        check("pkt_tail_op",  32'(op0),  32'b00100);
        check("pkt_tail_orc", 32'(orc0), 32'b10);
        // Back-to-back head right after the tail keeps route_valid high with the new route.
        set_hdr(xy(3,1), xy(1,1), xy(0,0));
        flit(1'b1, 1'b1, 1'b1);
        check("b2b_rv",  32'(rv0),  32'd1);
        check("b2b_op",  32'(op0),  32'b00001);
        check("b2b_orc", 32'(orc0), 32'b01);
        tick();
        check("b2b_rv_off", 32'(rv0), 32'd0);
        check("pkt_err",    32'(err0), 32'd0);

        // Body flit with no packet open.
        do_reset();
        flit(1'b1, 1'b0, 1'b0);
        check("idle_body_err", 32'(err0), 32'b01);
        check("idle_body_rv",  32'(rv0),  32'd0);
        tick();
        check("idle_body_sticky", 32'(err0), 32'b01);

        // Head arriving while a packet is open is dropped.
        do_reset();
        set_hdr(xy(1,1), xy(3,1), xy(0,2));
        flit(1'b1, 1'b1, 1'b0);
        check("busy_head_op0", 32'(op0), 32'b00010);
        set_hdr(xy(1,1), xy(1,0), xy(1,0));
        flit(1'b1, 1'b1, 1'b0);
        check("busy_head_err", 32'(err0), 32'b01);
        check("busy_head_op",  32'(op0),  32'b00010);
        check("busy_head_rv",  32'(rv0),  32'd1);
        flit(1'b1, 1'b0, 1'b1);
        tick();
        check("busy_head_close", 32'(rv0), 32'd0);

        // Reset in the middle of a packet, then its stray tail.
        do_reset();
        set_hdr(xy(3,1), xy(3,1), xy(3,0));
        flit(1'b1, 1'b1, 1'b0);
        check("midrst_pre_rv", 32'(rv0), 32'd1);
        do_reset();
        check("midrst_rv",  32'(rv0),  32'd0);
        check("midrst_op",  32'(op0),  32'd0);
        check("midrst_orc", 32'(orc0), 32'd0);
        flit(1'b1, 1'b0, 1'b1);
        check("midrst_tail_err", 32'(err0), 32'b01);
        check("midrst_tail_rv",  32'(rv0),  32'd0);

        // Ejection index beyond the node count is rejected.
        do_reset();
        set_hdr(xy(2,2), xy(2,2), xy(2,2));
        dest_node = 1'b1;
        flit(1'b1, 1'b1, 1'b1);
        check("bad_node_err", 32'(err0), 32'b01);
        check("bad_node_rv",  32'(rv0),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
